// File: rtl/audio_adc_sample_sequencer.sv
// Stereo ADC sample-pair FIFO with an Avalon-MM register front end.
// Pairs are pushed on sample_valid; reading RIGHT pops the head pair.
module audio_adc_sample_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adcl_data,
    input  logic [DATA_W-1:0] adcr_data,
    input  logic              sample_valid,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] left_mem  [DEPTH];
    logic [DATA_W-1:0] right_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;
    logic          irq_en;
    logic [4:0]    threshold;

    logic          rd_acc;
    logic          wr_acc;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          clear;
    logic          ovf_event;
    logic          ovf_clear;
    logic          ctrl_write;
    logic [4:0]    count5;
    logic [31:0]   status_word;
    logic [31:0]   control_word;
    logic [31:0]   rd_mux;
    logic          unused_wd;

    assign rd_acc     = chipselect & read;
    assign wr_acc     = chipselect & write;
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign count5     = 5'(count);
    assign ctrl_write = wr_acc & (address == 2'd3);
    assign clear      = ctrl_write & writedata[1];
    assign ovf_clear  = wr_acc & (address == 2'd2) & writedata[8];
    assign unused_wd  = ^{writedata[31:13], writedata[7:3]};

    // A pop while full frees a slot, so a coincident push is accepted instead of dropped.
    assign pop       = rd_acc & (address == 2'd1) & ~empty;
    assign push      = sample_valid & enable & (~full | pop) & ~clear;
    assign ovf_event = sample_valid & enable & full & ~pop;

    assign status_word  = {21'b0, full, empty, overflow, 3'b0, count5};
    assign control_word = {19'b0, threshold, 5'b0, irq_en, 1'b0, enable};

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: if (!empty) rd_mux = 32'(left_mem[rd_ptr]);
            2'd1: if (!empty) rd_mux = 32'(right_mem[rd_ptr]);
            2'd2: rd_mux = status_word;
            2'd3: rd_mux = control_word;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            left_mem[wr_ptr]  <= adcl_data;
            right_mem[wr_ptr] <= adcr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata  <= '0;
            irq       <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= '0;
        end else begin
            readdata <= rd_acc ? rd_mux : 32'd0;
            irq      <= irq_en & (((count5 >= threshold) & (threshold != 5'd0)) | overflow);

            if (clear) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                // A fresh overflow beats a software clear arriving the same cycle.
                if (ovf_event)      overflow <= 1'b1;
                else if (ovf_clear) overflow <= 1'b0;
            end

            if (ctrl_write) begin
                enable    <= writedata[0];
                irq_en    <= writedata[2];
                threshold <= writedata[12:8];
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_sample_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of the sample-pair FIFO and its register map.
module tb_audio_adc_sample_sequencer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic        clk;
    logic        reset;
    logic [31:0] adcl_data;
    logic [31:0] adcr_data;
    logic        sample_valid;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic        m_ovf;
    logic        m_en;
    logic        m_ien;
    logic [4:0]  m_thr;
    logic [31:0] exp_rd;
    logic        exp_irq;

    audio_adc_sample_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .adcl_data    (adcl_data),
        .adcr_data    (adcr_data),
        .sample_valid (sample_valid),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelStep(input logic rst, input logic sv,
                                      input logic [31:0] l, input logic [31:0] r,
                                      input logic cs, input logic rd, input logic wr,
                                      input logic [1:0] a, input logic [31:0] wd);
        int   n;
        logic rd_acc, wr_acc, pop_ok, clr, push_ok, ovf_evt;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_ien = 0; m_thr = 0;
            exp_rd = 0; exp_irq = 0;
            return;
        end
        n      = mq.size();
        rd_acc = cs && rd;
        wr_acc = cs && wr;
        exp_irq = m_ien && ((n >= int'(m_thr) && m_thr != 0) || m_ovf);
        exp_rd  = 0;
        if (rd_acc) begin
            case (a)
                2'd0: exp_rd = (n > 0) ? mq[0][63:32] : 32'd0;
                2'd1: exp_rd = (n > 0) ? mq[0][31:0]  : 32'd0;
                2'd2: exp_rd = {21'b0, (n == DEPTH), (n == 0), m_ovf, 3'b0, 5'(n)};
                default: exp_rd = {19'b0, m_thr, 5'b0, m_ien, 1'b0, m_en};
            endcase
        end
        pop_ok = rd_acc && a == 2'd1 && n > 0;
        clr    = wr_acc && a == 2'd3 && wd[1];
        if (clr) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            push_ok = sv && m_en && (n < DEPTH || pop_ok);
            ovf_evt = sv && m_en && n == DEPTH && !pop_ok;
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back({l, r});
            if (ovf_evt) m_ovf = 1;
            else if (wr_acc && a == 2'd2 && wd[8]) m_ovf = 0;
        end
        if (wr_acc && a == 2'd3) begin
            m_en  = wd[0];
            m_ien = wd[2];
            m_thr = wd[12:8];
        end
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_readdata"}, readdata, exp_rd);
        checkValue({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic sv,
                                 input logic [31:0] l, input logic [31:0] r,
                                 input logic cs, input logic rd, input logic wr,
                                 input logic [1:0] a, input logic [31:0] wd);
        reset = rst; sample_valid = sv; adcl_data = l; adcr_data = r;
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        modelStep(rst, sv, l, r, cs, rd, wr, a, wd);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle();
        applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic doReset(input logic sv);
        applyStimulus("reset", 1, sv, 32'hdead, 32'hbeef, 1, 1, 0, 2'd1, 0);
    endtask

    task automatic strobe(input logic [31:0] l, input logic [31:0] r);
        applyStimulus("strobe", 0, 1, l, r, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic regRead(input logic [1:0] a);
        applyStimulus("read", 0, 0, 0, 0, 1, 1, 0, a, 0);
    endtask

    task automatic regWrite(input logic [1:0] a, input logic [31:0] wd);
        applyStimulus("write", 0, 0, 0, 0, 1, 0, 1, a, wd);
    endtask

    initial begin
        reset = 1; sample_valid = 0; adcl_data = 0; adcr_data = 0;
        chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;

        // Basic push/read/pop
        doReset(0);
        checkValue("reset_readdata", readdata, 32'd0);
        checkValue("reset_irq", {31'b0, irq}, 32'd0);
        regWrite(2'd3, 32'h1);
        strobe(32'h1111, 32'h2222);
        regRead(2'd2); checkValue("basic_status1", readdata, 32'h001);
        regRead(2'd0); checkValue("basic_left", readdata, 32'h1111);
        regRead(2'd1); checkValue("basic_right", readdata, 32'h2222);
        regRead(2'd2); checkValue("basic_status2", readdata, 32'h200);
        regRead(2'd1); checkValue("empty_pop", readdata, 32'h0);

        // Overflow on a full FIFO
        doReset(0);
        regWrite(2'd3, 32'h1);
        for (int i = 1; i <= 5; i++) strobe(i, 32'h100 + i);
        regRead(2'd2); checkValue("ovf_status", readdata, 32'h504);
        for (int i = 1; i <= 4; i++) begin
            regRead(2'd1); checkValue("ovf_pop", readdata, 32'h100 + i);
        end
        regRead(2'd1); checkValue("ovf_pair5_absent", readdata, 32'h0);
        regWrite(2'd2, 32'h100);
        regRead(2'd2); checkValue("ovf_cleared", readdata, 32'h200);

        // Push coincident with pop while full
        doReset(0);
        regWrite(2'd3, 32'h1);
        for (int i = 1; i <= 4; i++) strobe(i, 32'h200 + i);
        applyStimulus("push_pop_full", 0, 1, 32'h55, 32'h299, 1, 1, 0, 2'd1, 0);
        checkValue("pp_head", readdata, 32'h201);
        regRead(2'd2); checkValue("pp_status", readdata, 32'h404);
        for (int i = 2; i <= 4; i++) begin
            regRead(2'd1); checkValue("pp_pop", readdata, 32'h200 + i);
        end
        regRead(2'd1); checkValue("pp_newest", readdata, 32'h299);

        // Overflow event beats a simultaneous status clear
        doReset(0);
        regWrite(2'd3, 32'h1);
        for (int i = 1; i <= 5; i++) strobe(i, i);
        applyStimulus("ovf_vs_clear", 0, 1, 9, 9, 1, 0, 1, 2'd2, 32'h100);
        regRead(2'd2); checkValue("ovf_wins", readdata, 32'h504);

        // Threshold interrupt
        doReset(0);
        regWrite(2'd3, 32'h205);
        strobe(1, 1);
        idle(); checkValue("irq_one_pair", {31'b0, irq}, 32'd0);
        strobe(2, 2);
        idle(); checkValue("irq_two_pairs", {31'b0, irq}, 32'd1);
        regRead(2'd1);
        idle(); checkValue("irq_after_pop", {31'b0, irq}, 32'd0);

        // Clear via CONTROL
        doReset(0);
        regWrite(2'd3, 32'h1);
        strobe(7, 8); strobe(9, 10);
        regWrite(2'd3, 32'h3);
        regRead(2'd2); checkValue("clr_status", readdata, 32'h200);
        regRead(2'd0); checkValue("clr_left", readdata, 32'h0);
        regRead(2'd3); checkValue("clr_ctrl", readdata, 32'h1);

        // Reset mid-operation with coincident strobe
        doReset(0);
        regWrite(2'd3, 32'h1);
        strobe(1, 1); strobe(2, 2); strobe(3, 3);
        doReset(1);
        checkValue("midrst_readdata", readdata, 32'h0);
        checkValue("midrst_irq", {31'b0, irq}, 32'd0);
        regRead(2'd2); checkValue("midrst_status", readdata, 32'h200);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic        sv, rst, cs, rd, wr;
            logic [1:0]  a;
            logic [31:0] wd;
            int          op;
            sv  = ($urandom_range(2) == 0);
            rst = ($urandom_range(499) == 0);
            a   = 2'($urandom_range(3));
            wd  = $urandom;
            cs = 0; rd = 0; wr = 0;
            op = int'($urandom_range(9));
            case (op)
                0, 1, 2: begin cs = 1; rd = 1; end
                3: begin
                    cs = 1; wr = 1; a = 2'd3;
                    wd[0] = ($urandom_range(7) != 0);
                    wd[1] = ($urandom_range(15) == 0);
                    wd[12:8] = 5'($urandom_range(5));
                end
                4: begin cs = 1; wr = 1; a = 2'd2; end
                5: begin cs = 1; wr = 1; a = 2'($urandom_range(1)); end
                6: begin cs = 0; rd = 1; a = 2'd1; end
                default: ;
            endcase
            applyStimulus("rand", rst, sv, $urandom, $urandom, cs, rd, wr, a, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_adc_sample_sequencer.md
AUDIO_ADC_SAMPLE_SEQUENCER -- requirements
Module: audio_adc_sample_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning stereo sample-pair FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning ADC sample width in bits (1..32).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port adcl_data  input  DATA_W  left ADC sample.
REQ-006 SHALL have port adcr_data  input  DATA_W  right ADC sample.
REQ-007 SHALL have port sample_valid  input  1  one-cycle strobe: adcl_data/adcr_data hold a new stereo pair.
REQ-008 SHALL have port address  input  2  Avalon-MM register select.
REQ-009 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-010 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-011 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-012 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-013 SHALL have port readdata  output  32  registered Avalon-MM read data.
REQ-014 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-015 Register map: 0 = LEFT (head pair left, read-only), 1 = RIGHT (head pair right, read pops), 2 = STATUS, 3 = CONTROL.
REQ-016 STATUS bits: [4:0] fill count, [8] overflow (sticky), [9] empty, [10] full; other bits read 0.
REQ-017 CONTROL bits: [0] enable, [1] clear (write-only, self-clearing, reads 0), [2] irq_en, [12:8] threshold; other bits read 0.
REQ-018 Read access = chipselect & read; write access = chipselect & write; read latency exactly 1 cycle.
REQ-019 readdata SHALL take the selected register value, zero-extended from DATA_W, on the cycle after a read access, and 0 on the cycle after any non-read cycle.
REQ-020 Push: sample_valid & enable & not full -> store {adcl_data, adcr_data} at tail, count+1.
REQ-021 sample_valid while enable=0 -> ignored; no count or flag change.
REQ-022 sample_valid & enable & full with no pop the same cycle -> pair dropped, overflow set to 1.
REQ-023 Pop: read access at address 1 with FIFO not empty -> readdata = head right sample, head advances, count-1.
REQ-024 Read of address 0 or 1 while empty -> readdata = 0, no pointer change.
REQ-025 Read of address 0 -> no pointer change.
REQ-026 Push and pop in the same cycle while full -> both take effect; count unchanged; overflow unchanged.
REQ-027 Push and pop in the same cycle while empty -> pop ignored, readdata = 0, push accepted, count = 1.
REQ-028 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-029 Write access to CONTROL with bit1 = 1 -> next cycle count = 0, pointers = 0, overflow = 0; enable/irq_en/threshold take writedata values; a push in that same cycle is discarded.
REQ-030 Write access to STATUS with bit8 = 1 -> overflow cleared; a simultaneous overflow event wins (overflow stays 1).
REQ-031 Writes to addresses 0 and 1 SHALL be ignored.
REQ-032 irq SHALL be registered: irq <= irq_en & (count >= threshold) & (threshold != 0) | irq_en & overflow, evaluated on current-cycle register values.
REQ-033 irq SHALL deassert one cycle after the condition clears.

Reset
REQ-034 On reset high at a clk edge: readdata = 0, irq = 0, count = 0, pointers = 0, overflow = 0, enable = 0, irq_en = 0, threshold = 0.
REQ-035 Reset asserted mid-operation SHALL discard all stored pairs and take priority over any simultaneous push, pop or write.
REQ-036 FIFO storage contents need not be reset; the empty state SHALL mask them (reads return 0).

Verification
REQ-037 Reset, write CONTROL=0x0000_0001, pulse sample_valid with L=0x1111, R=0x2222 -> STATUS reads 0x001; read addr0 -> 0x1111; read addr1 -> 0x2222; STATUS then reads 0x200.
REQ-038 DEPTH=4, enable, 5 strobes with L=1..5 -> STATUS = 0x504 (count 4, full, overflow); pops return R of pairs 1..4 in order; pair 5 absent.
REQ-039 Full FIFO, sample_valid coincident with addr1 pop -> count stays 4, overflow stays 0, newest pair appears after 3 further pops.
REQ-040 CONTROL = 0x0000_0205 (enable, irq_en, threshold 2) -> irq 0 after first pair, 1 one cycle after second pair registers, 0 one cycle after a pop drops count to 1.
REQ-041 Two pairs stored, write CONTROL = 0x0000_0003 -> STATUS = 0x200, addr0 read returns 0, enable still 1.
REQ-042 Reset asserted with 3 pairs stored and a simultaneous strobe -> after release STATUS = 0x200, irq = 0, readdata = 0.
